// File: rtl/aig_mix_in_packer_if.sv
// Handshake bundle between the inbound word stream, the packer and the mix-stage operand bus.
// The packer uses the slave view; the word source / vector sink uses the master view.
interface aig_mix_in_packer_if #(
    parameter int WORD_W = 16,
    parameter int VEC_W  = 112,
    parameter int CNT_W  = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [VEC_W-1:0]  m_data;
    logic              m_short;
    logic              m_nolast;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_short, m_nolast, frame_cnt
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_short, m_nolast, frame_cnt
    );
endinterface

// File: rtl/aig_mix_in_packer.sv
// Packs a stream of WORD_W words into one VEC_W operand, word 0 in the LSBs, and holds it
// steady on a registered output until the mix stage takes it. Flags short/unterminated frames.
module aig_mix_in_packer #(
    parameter int WORD_W = 16,
    parameter int VEC_W  = 112,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    aig_mix_in_packer_if.slave bus
);
    localparam int NWORDS = VEC_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [VEC_W-1:0]  r_data, w_data_nxt, w_base;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_widx;
    logic              r_short, w_short_nxt;
    logic              r_nolast, w_nolast_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_s_ready, w_acc, w_hs, w_term;

    // In HOLD a word can only enter in the same cycle the held vector leaves.
    assign w_s_ready = (r_state == FILL) || bus.m_ready;
    assign w_acc     = bus.s_valid && w_s_ready;
    assign w_hs      = (r_state == HOLD) && bus.m_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_idx_nxt    = r_idx;
        w_short_nxt  = r_short;
        w_nolast_nxt = r_nolast;
        w_cnt_nxt    = r_cnt;
        w_widx       = r_idx;
        w_base       = r_data;
        w_term       = 1'b0;

        if (w_hs) begin
            w_state_nxt  = FILL;
            w_data_nxt   = '0;
            w_idx_nxt    = '0;
            w_short_nxt  = 1'b0;
            w_nolast_nxt = 1'b0;
            w_widx       = '0;
            w_base       = '0;
            if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        // A word accepted during handoff lands on a cleared vector as word 0.
        if (w_acc) begin
            w_data_nxt = w_base;
            for (int k = 0; k < NWORDS; k++) begin
                if (w_widx == IDX_W'(k)) w_data_nxt[k*WORD_W +: WORD_W] = bus.s_data;
            end
            w_term = bus.s_last || (w_widx == LAST_IDX);
            if (w_term) begin
                w_state_nxt  = HOLD;
                w_idx_nxt    = '0;
                w_short_nxt  = bus.s_last && (w_widx != LAST_IDX);
                w_nolast_nxt = !bus.s_last && (w_widx == LAST_IDX);
            end else begin
                w_state_nxt  = FILL;
                w_idx_nxt    = w_widx + IDX_W'(1);
                w_short_nxt  = 1'b0;
                w_nolast_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_data   <= '0;
            r_idx    <= '0;
            r_short  <= 1'b0;
            r_nolast <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_idx    <= w_idx_nxt;
            r_short  <= w_short_nxt;
            r_nolast <= w_nolast_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = (r_state == HOLD);
    assign bus.m_data    = r_data;
    assign bus.m_short   = r_short;
    assign bus.m_nolast  = r_nolast;
    assign bus.frame_cnt = r_cnt;
endmodule

// File: tb/tb_aig_mix_in_packer.sv
// Bench for aig_mix_in_packer: directed frames plus randomized traffic against a
// frame-level reference model (word queue per frame, queue of completed vectors).
`timescale 1ns/1ps
module tb_aig_mix_in_packer;
    localparam int WORD_W = 16;
    localparam int VEC_W  = 112;
    localparam int CNT_W  = 16;
    localparam int NW     = VEC_W / WORD_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aig_mix_in_packer_if #(.WORD_W(WORD_W), .VEC_W(VEC_W), .CNT_W(CNT_W)) bus ();

    aig_mix_in_packer #(.WORD_W(WORD_W), .VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words of the open frame, and completed frames awaiting handoff.
    typedef struct {
        logic [VEC_W-1:0] d;
        logic             sh;
        logic             nl;
    } frm_t;

    logic [WORD_W-1:0] cur[$];
    frm_t              hold_q[$];
    int                mcnt = 0;
    logic              acc_q = 1'b0;
    logic              rnd_rdy = 1'b0;

    always @(negedge clk) begin
        logic exp_v, exp_r, acc, hs;
        frm_t f;
        if (!rst_n) begin
            cur.delete();
            hold_q.delete();
            mcnt  = 0;
            acc_q = 1'b0;
        end else begin
            exp_v = (hold_q.size() != 0);
            exp_r = !exp_v || bus.m_ready;
            check_eq("m_valid", bus.m_valid, exp_v);
            check_eq("s_ready", bus.s_ready, exp_r);
            check_eq("frame_cnt", bus.frame_cnt, mcnt);
            if (exp_v) begin
                check_eq("m_data", bus.m_data, hold_q[0].d);
                check_eq("m_short", bus.m_short, hold_q[0].sh);
                check_eq("m_nolast", bus.m_nolast, hold_q[0].nl);
            end
            acc = bus.s_valid && exp_r;
            hs  = exp_v && bus.m_ready;
            if (hs) begin
                void'(hold_q.pop_front());
                if (mcnt != (1 << CNT_W) - 1) mcnt++;
            end
            if (acc) begin
                cur.push_back(bus.s_data);
                if (bus.s_last || cur.size() == NW) begin
                    f.d = '0;
                    for (int i = 0; i < cur.size(); i++)
                        f.d = f.d | (VEC_W'(cur[i]) << (i * WORD_W));
                    f.sh = bus.s_last && (cur.size() < NW);
                    f.nl = !bus.s_last && (cur.size() == NW);
                    hold_q.push_back(f);
                    cur.delete();
                end
            end
            acc_q = acc;
        end
    end

    task automatic send_word(input logic [WORD_W-1:0] d, input logic l, output int ncyc);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        ncyc = 0;
        do begin
            @(posedge clk);
            ncyc++;
            #1;
            if (rnd_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
        end while (!acc_q && ncyc < 200);
        if (!acc_q) check_eq("accept_timeout", 1'b0, 1'b1);
        bus.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tot;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s_ready", bus.s_ready, 1'b1);
        check_eq("rst_m_valid", bus.m_valid, 1'b0);
        check_eq("rst_m_data", bus.m_data, '0);
        check_eq("rst_flags", {bus.m_short, bus.m_nolast}, 2'b00);
        check_eq("rst_cnt", bus.frame_cnt, '0);
        rst_n = 1'b1;

        // Full frame
        for (int i = 1; i <= NW; i++) send_word(WORD_W'(i), i == NW, n);
        check_eq("full_valid", bus.m_valid, 1'b1);
        check_eq("full_data", bus.m_data, 112'h0007_0006_0005_0004_0003_0002_0001);
        check_eq("full_flags", {bus.m_short, bus.m_nolast}, 2'b00);
        bus.m_ready = 1'b1;
        idle(1);
        check_eq("full_cnt", bus.frame_cnt, 1);
        check_eq("full_gone", bus.m_valid, 1'b0);

        // Short frame
        bus.m_ready = 1'b0;
        send_word(16'hAAAA, 1'b0, n);
        send_word(16'hBBBB, 1'b0, n);
        send_word(16'hCCCC, 1'b1, n);
        check_eq("short_data", bus.m_data, 112'h0000_CCCC_BBBB_AAAA);
        check_eq("short_flags", {bus.m_short, bus.m_nolast}, 2'b10);
        bus.m_ready = 1'b1;
        idle(1);

        // Missing last, then held under backpressure
        bus.m_ready = 1'b0;
        for (int i = 0; i < NW; i++) send_word(16'hFFFF, 1'b0, n);
        check_eq("nolast_data", bus.m_data, {VEC_W{1'b1}});
        check_eq("nolast_flags", {bus.m_short, bus.m_nolast}, 2'b01);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0101;
        bus.s_last  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("bp_s_ready", bus.s_ready, 1'b0);
            check_eq("bp_data", bus.m_data, {VEC_W{1'b1}});
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check_eq("bp_word0", bus.m_data, 112'h0101);
        check_eq("bp_cnt", bus.frame_cnt, 3);
        check_eq("bp_fill", bus.m_valid, 1'b0);
        for (int i = 2; i <= NW; i++) send_word(WORD_W'(16'h0100 + i), i == NW, n);
        idle(1);

        // Streaming two frames
        tot = 0;
        for (int i = 0; i < 2 * NW; i++) begin
            send_word(WORD_W'(16'h5000 + i), (i % NW) == NW - 1, n);
            tot += n;
        end
        check_eq("stream_cycles", tot, 2 * NW);
        idle(1);
        check_eq("stream_cnt", bus.frame_cnt, 6);

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send_word(WORD_W'(16'h0900 + i), 1'b0, n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_s_ready", bus.s_ready, 1'b1);
        check_eq("mrst_m_valid", bus.m_valid, 1'b0);
        check_eq("mrst_m_data", bus.m_data, '0);
        check_eq("mrst_flags", {bus.m_short, bus.m_nolast}, 2'b00);
        check_eq("mrst_cnt", bus.frame_cnt, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < NW; i++) send_word(WORD_W'(16'h0010 + i), i == NW - 1, n);
        check_eq("mrst_frame", bus.m_data, 112'h0016_0015_0014_0013_0012_0011_0010);
        bus.m_ready = 1'b1;
        idle(1);
        check_eq("mrst_cnt_after", bus.frame_cnt, 1);

        // Randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            send_word(16'($urandom), $urandom_range(0, 4) == 0, n);
        end
        rnd_rdy = 1'b0;
        bus.m_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
